// File: rtl/core_completion_monitor_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : core_mon_pkg
//  Description : Shared state encoding and default end-of-program opcode for
//                the multi-core completion monitor.
//  Revision    : 1.0 - initial release
// ============================================================================
package core_mon_pkg;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_RUN     = 3'd1;
  localparam logic [2:0] ST_DRAIN   = 3'd2;
  localparam logic [2:0] ST_DONE    = 3'd3;
  localparam logic [2:0] ST_TIMEOUT = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE    = ST_IDLE,
    S_RUN     = ST_RUN,
    S_DRAIN   = ST_DRAIN,
    S_DONE    = ST_DONE,
    S_TIMEOUT = ST_TIMEOUT
  } state_e;

  // Opcode the processor uses to mark end of program.
  localparam int unsigned ENDOP_DEFAULT = 122;

endpackage
`default_nettype wire

// File: rtl/core_completion_monitor_if.sv
`default_nettype none
// ============================================================================
//  Module      : core_mon_if
//  Description : Control/status bundle between the run controller (master)
//                and the completion monitor (slave).
//  Revision    : 1.0 - initial release
// ============================================================================
interface core_mon_if #(
  parameter int NUM_CORES = 4,
  parameter int INS_WIDTH = 8,
  parameter int CNT_WIDTH = 32
);
  localparam int LC_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

  logic                           start;
  logic [NUM_CORES-1:0]           core_en;
  logic [NUM_CORES*INS_WIDTH-1:0] ins;
  logic [NUM_CORES-1:0]           done_mask;
  logic [LC_W-1:0]                last_core;
  logic [CNT_WIDTH-1:0]           cycle_count;
  logic                           busy;
  logic                           all_done;
  logic                           finish;
  logic                           timeout;

  modport master (
    output start, core_en, ins,
    input  done_mask, last_core, cycle_count, busy, all_done, finish, timeout
  );

  modport slave (
    input  start, core_en, ins,
    output done_mask, last_core, cycle_count, busy, all_done, finish, timeout
  );
endinterface
`default_nettype wire

// File: rtl/core_completion_monitor_endop_detect.sv
`default_nettype none
// ============================================================================
//  Module      : endop_detect
//  Description : Per-core end-opcode comparator with a sticky done flag.
//                flag_next exposes the value the flag takes at the next edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module endop_detect #(
  parameter int          INS_WIDTH = 8,
  parameter int unsigned ENDOP     = 122
) (
  input  wire logic                 clk,
  input  wire logic                 rst_n,
  input  wire logic                 clr,
  input  wire logic                 en,
  input  wire logic [INS_WIDTH-1:0] ins,
  output logic                      flag,
  output logic                      flag_next
);

  logic flag_q;
  logic flag_d;

  // Clear wins over a hit; once set the flag holds until the next clear.
  always_comb begin
    flag_d = flag_q;
    if (clr) begin
      flag_d = 1'b0;
    end else if (en && (ins == INS_WIDTH'(ENDOP))) begin
      flag_d = 1'b1;
    end
  end

  // Flag register.
  always_ff @(posedge clk) begin
    if (!rst_n) flag_q <= 1'b0;
    else        flag_q <= flag_d;
  end

  assign flag      = flag_q;
  assign flag_next = flag_d;

endmodule
`default_nettype wire

// File: rtl/core_completion_monitor.sv
`default_nettype none
// ============================================================================
//  Module      : core_completion_monitor
//  Description : Watches every core's instruction bus for the end opcode,
//                counts run cycles, then drains and flags done or timeout.
//  Revision    : 1.0 - initial release
// ============================================================================
module core_completion_monitor
  import core_mon_pkg::*;
#(
  parameter int          NUM_CORES      = 4,
  parameter int          INS_WIDTH      = 8,
  parameter int unsigned ENDOP          = ENDOP_DEFAULT,
  parameter int unsigned DRAIN_CYCLES   = 5,
  parameter int unsigned TIMEOUT_CYCLES = 100000,
  parameter int          CNT_WIDTH      = 32
) (
  input wire logic clk,
  input wire logic rst_n,
  core_mon_if.slave bus
);

  localparam int LC_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
  localparam int DW   = (DRAIN_CYCLES > 0) ? $clog2(DRAIN_CYCLES + 1) : 1;

  state_e               state_q, state_d;
  logic [NUM_CORES-1:0] en_q, en_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [LC_W-1:0]      last_q, last_d;
  logic [DW-1:0]        drain_q, drain_d;
  logic                 finish_q, finish_d;

  logic [NUM_CORES-1:0] flag;
  logic [NUM_CORES-1:0] flag_next;
  logic [NUM_CORES-1:0] newly_set;
  logic [LC_W-1:0]      lowest_idx;
  logic [CNT_WIDTH-1:0] cnt_inc;
  logic                 start_ok;
  logic                 run_active;
  logic                 complete;

  assign start_ok   = bus.start && ((state_q == S_IDLE) || (state_q == S_DONE) ||
                                    (state_q == S_TIMEOUT));
  assign run_active = (state_q == S_RUN);
  assign cnt_inc    = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
  assign complete   = &(flag_next | ~en_q);
  assign newly_set  = flag_next & ~flag;

  for (genvar gi = 0; gi < NUM_CORES; gi++) begin : g_core
    endop_detect #(
      .INS_WIDTH (INS_WIDTH),
      .ENDOP     (ENDOP)
    ) u_detect (
      .clk       (clk),
      .rst_n     (rst_n),
      .clr       (start_ok),
      .en        (run_active && en_q[gi]),
      .ins       (bus.ins[gi*INS_WIDTH +: INS_WIDTH]),
      .flag      (flag[gi]),
      .flag_next (flag_next[gi])
    );
  end

  // Lowest index among flags that are set for the first time this cycle.
  always_comb begin
    lowest_idx = '0;
    for (int i = NUM_CORES - 1; i >= 0; i--) begin
      if (newly_set[i]) lowest_idx = LC_W'(i);
    end
  end

  // Next-state, counter and finish-pulse logic.
  always_comb begin
    state_d  = state_q;
    en_d     = en_q;
    cnt_d    = cnt_q;
    last_d   = last_q;
    drain_d  = drain_q;
    finish_d = 1'b0;
    case (state_q)
      S_IDLE, S_DONE, S_TIMEOUT: begin
        if (bus.start) begin
          en_d   = bus.core_en;
          cnt_d  = '0;
          last_d = '0;
          if (bus.core_en == '0) begin
            state_d  = S_DONE;
            finish_d = 1'b1;
          end else begin
            state_d = S_RUN;
          end
        end
      end
      S_RUN: begin
        cnt_d = cnt_inc;
        if (complete) begin
          last_d = lowest_idx;
          if (DRAIN_CYCLES == 0) begin
            state_d  = S_DONE;
            finish_d = 1'b1;
          end else begin
            state_d = S_DRAIN;
            drain_d = DW'(DRAIN_CYCLES);
          end
        end else if ((TIMEOUT_CYCLES != 0) && (cnt_inc == CNT_WIDTH'(TIMEOUT_CYCLES))) begin
          state_d = S_TIMEOUT;
        end
      end
      S_DRAIN: begin
        drain_d = drain_q - 1'b1;
        if (drain_q == DW'(1)) begin
          state_d  = S_DONE;
          finish_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and counter registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      en_q     <= '0;
      cnt_q    <= '0;
      last_q   <= '0;
      drain_q  <= '0;
      finish_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      en_q     <= en_d;
      cnt_q    <= cnt_d;
      last_q   <= last_d;
      drain_q  <= drain_d;
      finish_q <= finish_d;
    end
  end

  assign bus.done_mask   = flag;
  assign bus.last_core   = last_q;
  assign bus.cycle_count = cnt_q;
  assign bus.busy        = (state_q == S_RUN) || (state_q == S_DRAIN);
  assign bus.all_done    = (state_q == S_DONE);
  assign bus.finish      = finish_q;
  assign bus.timeout     = (state_q == S_TIMEOUT);

endmodule
`default_nettype wire

// File: tb/tb_core_completion_monitor.sv
`default_nettype none
// ============================================================================
//  Module      : tb_core_completion_monitor
//  Description : Directed bench for the completion monitor. dut0 drains for
//                5 cycles, dut1 is the zero-drain build; both share stimulus.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_core_completion_monitor;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [3:0]  core_en;
  logic [31:0] ins;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  core_mon_if #(.NUM_CORES(4), .INS_WIDTH(8), .CNT_WIDTH(32)) bus0 ();
  core_mon_if #(.NUM_CORES(4), .INS_WIDTH(8), .CNT_WIDTH(32)) bus1 ();

  assign bus0.start   = start;
  assign bus0.core_en = core_en;
  assign bus0.ins     = ins;
  assign bus1.start   = start;
  assign bus1.core_en = core_en;
  assign bus1.ins     = ins;

  core_completion_monitor #(
    .NUM_CORES(4), .INS_WIDTH(8), .ENDOP(122),
    .DRAIN_CYCLES(5), .TIMEOUT_CYCLES(50), .CNT_WIDTH(32)
  ) dut0 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus0)
  );

  core_completion_monitor #(
    .NUM_CORES(4), .INS_WIDTH(8), .ENDOP(122),
    .DRAIN_CYCLES(0), .TIMEOUT_CYCLES(50), .CNT_WIDTH(32)
  ) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1)
  );

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [3:0] en);
    core_en = en;
    start   = 1'b1;
    tick();
    start   = 1'b0;
  endtask

  function automatic logic [7:0] op(input bit hit);
    return hit ? 8'd122 : 8'd0;
  endfunction

  initial begin
    rst_n = 1'b0; start = 1'b0; core_en = '0; ins = '0;
    repeat (2) tick();
    check("rst_busy",     bus0.busy, 1'b0);
    check("rst_all_done", bus0.all_done, 1'b0);
    check("rst_finish",   bus0.finish, 1'b0);
    check("rst_timeout",  bus0.timeout, 1'b0);
    check("rst_mask",     bus0.done_mask, 4'h0);
    check("rst_cnt",      bus0.cycle_count, 32'd0);
    check("rst_last",     bus0.last_core, 2'd0);
    rst_n = 1'b1;
    tick();

    // Staggered completion: cores 0..3 end on RUN cycles 3, 7, 10, 10.
    do_start(4'hF);
    check("stag_busy0", bus0.busy, 1'b1);
    check("stag_cnt0",  bus0.cycle_count, 32'd0);
    for (int k = 1; k <= 10; k++) begin
      ins = {op(k >= 10), op(k >= 10), op(k >= 7), op(k >= 3)};
      tick();
      check("stag_mask", bus0.done_mask, {k >= 10, k >= 10, k >= 7, k >= 3});
    end
    check("stag_last",    bus0.last_core, 2'd2);
    check("stag_cnt",     bus0.cycle_count, 32'd10);
    check("stag_busy",    bus0.busy, 1'b1);
    check("stag_nodone",  bus0.all_done, 1'b0);
    check("d0_all_done",  bus1.all_done, 1'b1);
    check("d0_finish",    bus1.finish, 1'b1);
    check("d0_busy",      bus1.busy, 1'b0);
    ins = '0;
    repeat (4) tick();
    check("stag_drain_done", bus0.all_done, 1'b0);
    check("stag_drain_busy", bus0.busy, 1'b1);
    tick();
    check("stag_all_done", bus0.all_done, 1'b1);
    check("stag_finish",   bus0.finish, 1'b1);
    check("stag_busy_off", bus0.busy, 1'b0);
    check("stag_cnt_frz",  bus0.cycle_count, 32'd10);
    check("d0_finish_off", bus1.finish, 1'b0);
    tick();
    check("stag_finish_off", bus0.finish, 1'b0);
    check("stag_done_hold",  bus0.all_done, 1'b1);

    // Disabled core 2 shows the end opcode throughout but must never flag.
    do_start(4'b1011);
    for (int k = 1; k <= 6; k++) begin
      ins = {op(k >= 6), op(1'b1), op(k >= 4), op(k >= 2)};
      tick();
      check("dis_mask", bus0.done_mask, {k >= 6, 1'b0, k >= 4, k >= 2});
    end
    check("dis_last", bus0.last_core, 2'd3);
    check("dis_cnt",  bus0.cycle_count, 32'd6);
    repeat (5) tick();
    check("dis_all_done", bus0.all_done, 1'b1);
    check("dis_mask_end", bus0.done_mask, 4'b1011);

    // Timeout: core 3 never ends.
    do_start(4'hF);
    ins = {op(1'b0), op(1'b1), op(1'b1), op(1'b1)};
    repeat (49) tick();
    check("to_pre_timeout", bus0.timeout, 1'b0);
    check("to_pre_cnt",     bus0.cycle_count, 32'd49);
    tick();
    check("to_timeout",  bus0.timeout, 1'b1);
    check("to_cnt",      bus0.cycle_count, 32'd50);
    check("to_all_done", bus0.all_done, 1'b0);
    check("to_busy",     bus0.busy, 1'b0);
    check("to_mask",     bus0.done_mask, 4'b0111);
    tick();
    check("to_hold", bus0.timeout, 1'b1);
    do_start(4'hF);
    check("rs_busy",    bus0.busy, 1'b1);
    check("rs_timeout", bus0.timeout, 1'b0);
    check("rs_cnt",     bus0.cycle_count, 32'd0);
    check("rs_mask",    bus0.done_mask, 4'h0);

    // Boundary: core 3 ends exactly on RUN cycle 50.
    repeat (49) tick();
    ins = {op(1'b1), op(1'b1), op(1'b1), op(1'b1)};
    tick();
    check("bnd_busy",    bus0.busy, 1'b1);
    check("bnd_timeout", bus0.timeout, 1'b0);
    check("bnd_cnt",     bus0.cycle_count, 32'd50);
    check("bnd_last",    bus0.last_core, 2'd3);
    check("bnd_d0_done", bus1.all_done, 1'b1);
    check("bnd_d0_to",   bus1.timeout, 1'b0);
    repeat (5) tick();
    check("bnd_all_done", bus0.all_done, 1'b1);

    // Reset during DRAIN; start is ignored while busy.
    do_start(4'hF);
    tick();
    check("rm_cnt1", bus0.cycle_count, 32'd1);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("rm_ign_busy", bus0.busy, 1'b1);
    check("rm_ign_cnt",  bus0.cycle_count, 32'd1);
    check("rm_ign_mask", bus0.done_mask, 4'hF);
    rst_n = 1'b0;
    tick();
    check("rm_busy",     bus0.busy, 1'b0);
    check("rm_mask",     bus0.done_mask, 4'h0);
    check("rm_cnt",      bus0.cycle_count, 32'd0);
    check("rm_last",     bus0.last_core, 2'd0);
    check("rm_all_done", bus0.all_done, 1'b0);
    check("rm_timeout",  bus0.timeout, 1'b0);
    check("rm_finish",   bus0.finish, 1'b0);
    rst_n = 1'b1;
    ins   = '0;
    tick();

    // Transient opcode on core 1, start pulsed mid-run.
    do_start(4'hF);
    ins = {op(1'b0), op(1'b0), op(1'b1), op(1'b0)};
    tick();
    ins   = '0;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("tr_mask", bus0.done_mask, 4'b0010);
    check("tr_cnt",  bus0.cycle_count, 32'd2);
    check("tr_busy", bus0.busy, 1'b1);
    ins = {op(1'b1), op(1'b1), op(1'b1), op(1'b1)};
    tick();
    check("tr_mask_all", bus0.done_mask, 4'hF);
    check("tr_last",     bus0.last_core, 2'd0);
    check("tr_cnt3",     bus0.cycle_count, 32'd3);
    repeat (5) tick();
    check("tr_all_done", bus0.all_done, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
